// File: rtl/sha256_search_ctrl.sv
`default_nettype none
// ============================================================================
// sha256_search_ctrl: steps a nonce range through a pipelined SHA-256 match core
// Revision: 1.0
// ============================================================================
module sha256_search_ctrl #(
  parameter int LATENCY = 2,
  parameter int NONCE_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [511-NONCE_W:0]  prefix_i,
  input  logic [NONCE_W-1:0]    nonce_start_i,
  input  logic [NONCE_W-1:0]    nonce_end_i,
  input  logic [7:0]            difficulty_i,
  output logic [511:0]          d_o,
  output logic [7:0]            num_zero_o,
  input  logic                  matched_i,
  input  logic [511:0]          original_i,
  input  logic [255:0]          hash_i,
  output logic                  busy_o,
  output logic                  found_o,
  output logic                  exhausted_o,
  output logic [511:0]          result_block_o,
  output logic [255:0]          result_hash_o,
  output logic [NONCE_W-1:0]    result_nonce_o,
  output logic [NONCE_W:0]      attempts_o
);

  localparam logic [NONCE_W-1:0] NONCE_ONE = 1;
  localparam logic [NONCE_W:0]   ATT_ONE   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [LATENCY-1:0]   vpipe;
  logic [NONCE_W-1:0]   nonce_end;
  logic [NONCE_W-1:0]   cur_nonce;
  logic                 in_search;
  logic                 qualified;
  logic                 hit;
  logic                 start_ok;
  logic                 last_issue;

  // d_o itself is the nonce counter; its upper bits hold the latched prefix.
  assign cur_nonce  = d_o[NONCE_W-1:0];
  assign in_search  = (state == RUN) || (state == DRAIN);
  assign qualified  = vpipe[LATENCY-1];
  assign hit        = in_search && qualified && matched_i;
  assign start_ok   = ((state == IDLE) || (state == DONE)) && start_i && !abort_i;
  assign last_issue = (cur_nonce == nonce_end);
  assign busy_o     = in_search;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (abort_i) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start_i) state_n = RUN;
        RUN:        if (hit) state_n = DONE;
                    else if (last_issue) state_n = DRAIN;
        DRAIN:      if (hit || (vpipe == '0)) state_n = DONE;
        default:    state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_o            <= '0;
      num_zero_o     <= '0;
      nonce_end      <= '0;
      vpipe          <= '0;
      found_o        <= 1'b0;
      exhausted_o    <= 1'b0;
      result_block_o <= '0;
      result_hash_o  <= '0;
      result_nonce_o <= '0;
      attempts_o     <= '0;
    end else begin
      if (in_search && qualified && !abort_i)
        attempts_o <= attempts_o + ATT_ONE;

      if (abort_i) begin
        vpipe       <= '0;
        found_o     <= 1'b0;
        exhausted_o <= 1'b0;
      end else if (start_ok) begin
        d_o         <= {prefix_i, nonce_start_i};
        nonce_end   <= nonce_end_i;
        num_zero_o  <= difficulty_i;
        vpipe       <= '0;
        attempts_o  <= '0;
        found_o     <= 1'b0;
        exhausted_o <= 1'b0;
      end else if (hit) begin
        result_block_o <= original_i;
        result_hash_o  <= hash_i;
        result_nonce_o <= original_i[NONCE_W-1:0];
        found_o        <= 1'b1;
        vpipe          <= '0;
      end else if (state == RUN) begin
        // The block on d_o this cycle enters the core; the valid bit tracks it.
        vpipe <= (vpipe << 1) | LATENCY'(1'b1);
        if (!last_issue)
          d_o <= {d_o[511:NONCE_W], cur_nonce + NONCE_ONE};
      end else if (state == DRAIN) begin
        vpipe <= vpipe << 1;
        if (vpipe == '0)
          exhausted_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_search_ctrl.sv
`default_nettype none
// Directed bench for sha256_search_ctrl with a 2-cycle behavioural match core.
module tb_sha256_search_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic [479:0] prefix_i = '0;
  logic [31:0]  nonce_start_i = '0;
  logic [31:0]  nonce_end_i = '0;
  logic [7:0]   difficulty_i = '0;
  logic [511:0] d_o;
  logic [7:0]   num_zero_o;
  logic         matched_i;
  logic [511:0] original_i;
  logic [255:0] hash_i;
  logic         busy_o, found_o, exhausted_o;
  logic [511:0] result_block_o;
  logic [255:0] result_hash_o;
  logic [31:0]  result_nonce_o;
  logic [32:0]  attempts_o;

  int vectors = 0;
  int errors  = 0;

  sha256_search_ctrl #(.LATENCY(2), .NONCE_W(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .abort_i(abort_i),
    .prefix_i(prefix_i), .nonce_start_i(nonce_start_i), .nonce_end_i(nonce_end_i),
    .difficulty_i(difficulty_i), .d_o(d_o), .num_zero_o(num_zero_o),
    .matched_i(matched_i), .original_i(original_i), .hash_i(hash_i),
    .busy_o(busy_o), .found_o(found_o), .exhausted_o(exhausted_o),
    .result_block_o(result_block_o), .result_hash_o(result_hash_o),
    .result_nonce_o(result_nonce_o), .attempts_o(attempts_o)
  );

  always #5 clk = ~clk;

  // Core model: two register stages, matches one target nonce or is forced high.
  logic [511:0] p0, p1;
  logic         match_en = 1'b0;
  logic         force_match = 1'b0;
  logic [31:0]  target = '0;
  always @(posedge clk) begin
    p0 <= d_o;
    p1 <= p0;
  end
  assign original_i = p1;
  assign hash_i     = {8{p1[31:0] ^ 32'hA5A5A5A5}};
  assign matched_i  = force_match || (match_en && (p1[31:0] == target));

  // Distinct nonces presented on d_o while searching.
  logic [31:0] seen[$];
  always @(negedge clk) begin
    if (busy_o && ((seen.size() == 0) || (d_o[31:0] != seen[$])))
      seen.push_back(d_o[31:0]);
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_search(input logic [479:0] pfx, input logic [31:0] ns,
                              input logic [31:0] ne, input logic [7:0] diff);
    @(negedge clk);
    seen.delete();
    prefix_i = pfx; nonce_start_i = ns; nonce_end_i = ne; difficulty_i = diff;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (busy_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, {511'd0, busy_o}, 512'd0);
  endtask

  logic [479:0] pfx_a, pfx_b;

  initial begin
    pfx_a = {15{32'hC0DE0001}};
    pfx_b = {15{32'hBEEF0002}};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_d", d_o, 512'd0);
    check("rst_busy", {511'd0, busy_o}, 512'd0);
    check("rst_attempts", {479'd0, attempts_o}, 512'd0);
    check("rst_result", result_block_o, 512'd0);

    // Range 5..9, match on 7; match lands while 9 is on d_o.
    match_en = 1'b1; target = 32'd7;
    start_search(pfx_a, 32'd5, 32'd9, 8'd12);
    wait_done("s1_timeout");
    check("s1_found", {511'd0, found_o}, 512'd1);
    check("s1_exh", {511'd0, exhausted_o}, 512'd0);
    check("s1_nonce", {480'd0, result_nonce_o}, 512'd7);
    check("s1_attempts", {479'd0, attempts_o}, 512'd3);
    check("s1_block", result_block_o, {pfx_a, 32'd7});
    check("s1_hash", {256'd0, result_hash_o}, {256'd0, {8{32'hA5A5A5A2}}});
    check("s1_issued", seen.size(), 5);
    check("s1_last_d", {480'd0, d_o[31:0]}, 512'd9);

    // Wrap-around range without a match.
    match_en = 1'b0;
    start_search(pfx_b, 32'hFFFF_FFFE, 32'h0000_0001, 8'd3);
    wait_done("s2_timeout");
    check("s2_exh", {511'd0, exhausted_o}, 512'd1);
    check("s2_found", {511'd0, found_o}, 512'd0);
    check("s2_attempts", {479'd0, attempts_o}, 512'd4);
    check("s2_issued", seen.size(), 4);
    if (seen.size() == 4) begin
      check("s2_n0", {480'd0, seen[0]}, {480'd0, 32'hFFFF_FFFE});
      check("s2_n1", {480'd0, seen[1]}, {480'd0, 32'hFFFF_FFFF});
      check("s2_n2", {480'd0, seen[2]}, 512'd0);
      check("s2_n3", {480'd0, seen[3]}, 512'd1);
    end

    // Match line stuck high; only the qualified result counts.
    force_match = 1'b1;
    start_search(pfx_a, 32'd3, 32'd3, 8'd1);
    wait_done("s3_timeout");
    check("s3_found", {511'd0, found_o}, 512'd1);
    check("s3_nonce", {480'd0, result_nonce_o}, 512'd3);
    check("s3_attempts", {479'd0, attempts_o}, 512'd1);
    force_match = 1'b0;

    // Abort in the second RUN cycle.
    start_search(pfx_b, 32'd0, 32'd100, 8'd4);
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("s4_busy", {511'd0, busy_o}, 512'd0);
    check("s4_found", {511'd0, found_o}, 512'd0);
    force_match = 1'b1;
    repeat (5) @(negedge clk);
    force_match = 1'b0;
    check("s4_found_late", {511'd0, found_o}, 512'd0);
    check("s4_busy_late", {511'd0, busy_o}, 512'd0);
    check("s4_held_nonce", {480'd0, result_nonce_o}, 512'd3);
    check("s4_attempts", {479'd0, attempts_o}, 512'd0);

    // Difficulty latched and held while inputs change mid-search.
    start_search(pfx_a, 32'd0, 32'd3, 8'd20);
    check("s5_nz_first", {504'd0, num_zero_o}, 512'd20);
    prefix_i = pfx_b; difficulty_i = 8'd99;
    @(negedge clk);
    check("s5_nz_mid", {504'd0, num_zero_o}, 512'd20);
    check("s5_prefix", {32'd0, d_o[511:32]}, {32'd0, pfx_a});
    wait_done("s5_timeout");
    check("s5_nz_done", {504'd0, num_zero_o}, 512'd20);
    check("s5_exh", {511'd0, exhausted_o}, 512'd1);
    check("s5_attempts", {479'd0, attempts_o}, 512'd4);
    start_search(pfx_b, 32'd0, 32'd0, 8'd5);
    check("s5_nz_next", {504'd0, num_zero_o}, 512'd5);
    wait_done("s5b_timeout");

    // Reset in DRAIN on the same edge as a qualified match.
    match_en = 1'b1; target = 32'd10;
    start_search(pfx_a, 32'd10, 32'd10, 8'd7);
    @(negedge clk);
    check("s6_busy", {511'd0, busy_o}, 512'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    match_en = 1'b0;
    check("s6_d", d_o, 512'd0);
    check("s6_nz", {504'd0, num_zero_o}, 512'd0);
    check("s6_busy_after", {511'd0, busy_o}, 512'd0);
    check("s6_found", {511'd0, found_o}, 512'd0);
    check("s6_exh", {511'd0, exhausted_o}, 512'd0);
    check("s6_block", result_block_o, 512'd0);
    check("s6_hash", {256'd0, result_hash_o}, 512'd0);
    check("s6_nonce", {480'd0, result_nonce_o}, 512'd0);
    check("s6_attempts", {479'd0, attempts_o}, 512'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha256_search_ctrl.md
SHA256_SEARCH_CTRL -- requirements
Module: sha256_search_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 2: the number of cycles from a block on d_o to its result on matched_i/original_i/hash_i.
REQ-002 SHALL have parameter NONCE_W, default 32: nonce width; the nonce occupies the block's low bits.
REQ-003 SHALL use a single clock and a synchronous active-high reset, named clk and reset.
REQ-004 clk  in  1  sole clock, all state on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start_i  in  1  begin search; sampled in IDLE or DONE only.
REQ-007 abort_i  in  1  cancel search; return to IDLE.
REQ-008 prefix_i  in  512-NONCE_W  fixed upper block bits, latched at start.
REQ-009 nonce_start_i  in  NONCE_W  first nonce, latched at start.
REQ-010 nonce_end_i  in  NONCE_W  last nonce (inclusive), latched at start.
REQ-011 difficulty_i  in  8  required leading-zero count, latched at start.
REQ-012 d_o  out  512  candidate block to the hash core, {prefix, nonce}.
REQ-013 num_zero_o  out  8  latched difficulty to the hash core.
REQ-014 matched_i  in  1  hash core match flag.
REQ-015 original_i  in  512  hash core echoed block.
REQ-016 hash_i  in  256  hash core digest.
REQ-017 busy_o  out  1  high in RUN and DRAIN.
REQ-018 found_o  out  1  high in DONE when a match was captured.
REQ-019 exhausted_o  out  1  high in DONE when the range completed without a match.
REQ-020 result_block_o  out  512  captured original_i.
REQ-021 result_hash_o  out  256  captured hash_i.
REQ-022 result_nonce_o  out  NONCE_W  low NONCE_W bits of the captured original_i.
REQ-023 attempts_o  out  NONCE_W+1  count of qualified results evaluated in the current search.

Function
REQ-024 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-025 In IDLE/DONE with start_i=1 and abort_i=0: SHALL latch all inputs, clear attempts_o/found_o/exhausted_o and go to RUN; the first block appears on d_o in the next cycle.
REQ-026 In RUN, each cycle SHALL present d_o={prefix,nonce} and shift a 1 into a LATENCY-deep valid pipe; nonce then increments modulo 2^NONCE_W.
REQ-027 When the issued nonce equals nonce_end: SHALL go to DRAIN and issue no more blocks; the valid pipe shifts in 0 thereafter.
REQ-028 Wrap-around: nonce_end < nonce_start SHALL search through all-ones, then 0, to nonce_end; nonce_end == nonce_start SHALL issue exactly one block.
REQ-029 A qualified result is matched_i sampled while the valid pipe output is 1; any matched_i with the pipe output at 0 (post-reset garbage, stale blocks) SHALL be ignored.
REQ-030 Each qualified result SHALL increment attempts_o, whether or not it matched.
REQ-031 Qualified matched_i=1 in RUN or DRAIN: SHALL capture original_i/hash_i/nonce, set found_o, stop issuing immediately, clear the valid pipe and go to DONE.
REQ-032 When the first qualified match coincides with a last-block issue, the match SHALL take precedence.
REQ-033 In DRAIN, when the valid pipe is empty with no match: SHALL go to DONE with exhausted_o=1.
REQ-034 abort_i SHALL take precedence over start_i and any match in any state: next state IDLE, valid pipe cleared, result registers held, found_o/exhausted_o cleared.
REQ-035 num_zero_o SHALL be held constant for the whole search and passed unmodified; difficulty is interpreted by the core.
REQ-036 d_o SHALL hold its last value outside RUN.
REQ-037 result_* outputs SHALL change only on a capture or reset.

Reset
REQ-038 reset SHALL set state IDLE and zero d_o, num_zero_o, the valid pipe, busy_o, found_o, exhausted_o, result_block_o, result_hash_o, result_nonce_o and attempts_o.
REQ-039 reset asserted mid-search SHALL abandon the search in that cycle; no capture occurs on that edge.

Verification
REQ-040 Scenario: LATENCY=2 core model, nonce 5..9, model matches only nonce 7 -> found_o=1, result_nonce_o=7, attempts_o=3, d_o never carries a nonce greater than 9.
REQ-041 Scenario: nonce 0xFFFFFFFE..0x00000001, no match -> 4 blocks issued (FFFFFFFE, FFFFFFFF, 0, 1), exhausted_o=1, attempts_o=4.
REQ-042 Scenario: model asserts matched_i constantly from reset, start at nonce 3..3 -> only the qualified result counts, result_nonce_o=3, attempts_o=1.
REQ-043 Scenario: abort_i pulsed in cycle 2 of RUN (range 0..100) -> IDLE next cycle, busy_o=0, found_o=0, later matched_i pulses ignored.
REQ-044 Scenario: start with difficulty_i=20 -> num_zero_o=20 from the first block until the next start, including after prefix_i/difficulty_i change mid-search.
REQ-045 Scenario: reset asserted in DRAIN with a match arriving the same cycle -> all outputs zero, state IDLE, no capture.
